ck_rst_gen: RTL
===============

CK_RST_GEN -- requirements
Module: ck_rst_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of reset synchronizer flops; legal range 2 or more.
REQ-002 Parameter RST_CYCLES, default 2: reset hold length in clock periods; legal range 1 or more.
REQ-003 Parameter DIV_W, default 16: width of the tick divider input and the tick counter.
REQ-004 Port clk, input, 1: the single clock; all flops SHALL be clocked on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port sw_rst_req, input, 1: synchronous soft-reset request, sampled on the rising clk edge.
REQ-007 Port div, input, DIV_W: tick period in clk cycles; value 0 SHALL be treated as 1.
REQ-008 Port rst_sync_n, output, 1: registered reset for downstream logic; asserts asynchronously and releases synchronously.
REQ-009 Port run, output, 1: registered; 1 exactly when the FSM is in RUN.
REQ-010 Port tick, output, 1: registered single-cycle clock-enable pulse.

Function
REQ-011 The block SHALL implement a three-state FSM with states RESET, HOLD and RUN.
REQ-012 The SYNC_STAGES-deep synchronizer SHALL shift in 1 each edge while rst_n=1; its last stage is sync_q.
REQ-013 RESET -> HOLD: on the edge where sync_q=1 is sampled; the hold counter loads 0 on this transition.
REQ-014 HOLD: the hold counter increments each edge; HOLD -> RUN on the edge where the counter reaches RST_CYCLES.
REQ-015 Release latency: rst_sync_n and run SHALL rise on rising edge number SYNC_STAGES+1+RST_CYCLES after rst_n deasserts; with default parameters this is the 5th edge.
REQ-016 rst_sync_n SHALL be 0 in RESET and HOLD and 1 in RUN; it SHALL be driven from a flop, never combinationally.
REQ-017 RUN with sw_rst_req=1 sampled at edge k: the FSM enters HOLD and rst_sync_n=0 from edge k; RUN is re-entered at edge k+RST_CYCLES.
REQ-018 sw_rst_req=1 while in HOLD SHALL clear the hold counter, restarting the full RST_CYCLES hold.
REQ-019 sw_rst_req SHALL be ignored in RESET.
REQ-020 Tick divider: an internal period register div_q (DIV_W bits) SHALL be loaded with max(div,1) on entry to RUN and on each tick.
REQ-021 Tick counter: cleared on entry to RUN, it increments each RUN cycle; when it equals div_q-1, tick=1 for that one cycle and the counter wraps to 0.
REQ-022 Tick timing: the first tick falls on edge r+div_q after RUN entry at edge r, then every div_q edges; div_q=1 holds tick at 1 continuously from edge r+1.
REQ-023 A change of div mid-period SHALL take effect only after the current period's tick.
REQ-024 Leaving RUN (soft reset or rst_n) SHALL clear the tick counter and force tick=0 on the same edge, or asynchronously for rst_n.
REQ-025 The counter SHALL never exceed div_q-1; no overflow at div = 2^DIV_W-1.

Reset
REQ-026 rst_n=0 SHALL asynchronously force: FSM=RESET, all synchronizer stages=0, hold counter=0, tick counter=0, div_q=1, rst_sync_n=0, run=0, tick=0.
REQ-027 rst_n asserted mid-HOLD or mid-RUN SHALL take effect immediately with no pending tick; the full release sequence of REQ-015 SHALL repeat after deassertion.
REQ-028 rst_n deasserting in the same cycle as sw_rst_req=1 SHALL follow REQ-019: the request is ignored.

Verification
REQ-029 Power-up: defaults, rst_n low for 3 cycles then released -> rst_sync_n=0 through edge 4 and 1 from edge 5; run matches rst_sync_n.
REQ-030 Tick period: div=4 in RUN -> tick high one cycle at RUN-entry edge +4, +8, +12; never two consecutive cycles.
REQ-031 Soft reset: sw_rst_req one-cycle pulse in RUN at edge k -> rst_sync_n 0 at edges k..k+1 and 1 at k+2; tick resumes at k+2+div.
REQ-032 Soft reset in HOLD: second sw_rst_req one cycle after the first -> release delayed by one further cycle (RUN at first edge + 3).
REQ-033 Async abort: rst_n dropped mid-RUN between edges -> rst_sync_n, run and tick go 0 before the next edge; re-release repeats the 5-edge latency.
REQ-034 Divider edge cases: div=0 and div=1 -> tick=1 every RUN cycle after the first; div changed 2->5 mid-period -> one final 2-cycle period, then 5-cycle periods.

Source files
------------

// File: rtl/ck_rst_gen.sv
// ck_rst_gen: reset synchronizer with hold/soft-reset FSM and a programmable tick divider.
module ck_rst_gen #(
   parameter int SYNC_STAGES = 2,
   parameter int RST_CYCLES  = 2,
   parameter int DIV_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sw_rst_req,
   input  logic [DIV_W-1:0] div,
   output logic             rst_sync_n,
   output logic             run,
   output logic             tick
);
   localparam int HW = $clog2(RST_CYCLES + 1);
   typedef enum logic [1:0] {RESET, HOLD, RUN} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] sync;
   logic [HW-1:0] hold_cnt;
   logic [DIV_W-1:0] div_q, tick_cnt, div_eff;
   logic sync_q;
   assign sync_q = sync[SYNC_STAGES-1];
   assign div_eff = (div == '0) ? DIV_W'(1) : div;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RESET;
         sync       <= '0;
         hold_cnt   <= '0;
         tick_cnt   <= '0;
         div_q      <= DIV_W'(1);
         rst_sync_n <= 1'b0;
         run        <= 1'b0;
         tick       <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], 1'b1};
         case (state)
            RESET: if (sync_q) begin
               state    <= HOLD;
               hold_cnt <= '0;
            end
            HOLD: if (sw_rst_req) begin
               hold_cnt <= '0;
            end else if (hold_cnt + 1'b1 == HW'(RST_CYCLES)) begin
               state      <= RUN;
               hold_cnt   <= '0;
               rst_sync_n <= 1'b1;
               run        <= 1'b1;
               div_q      <= div_eff;
               tick_cnt   <= '0;
               tick       <= 1'b0;
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
            RUN: if (sw_rst_req) begin
               state      <= HOLD;
               hold_cnt   <= '0;
               rst_sync_n <= 1'b0;
               run        <= 1'b0;
               tick_cnt   <= '0;
               tick       <= 1'b0;
            end else if (tick_cnt == div_q - 1'b1) begin
               // period ends: a new div only takes effect from here
               tick     <= 1'b1;
               tick_cnt <= '0;
               div_q    <= div_eff;
            end else begin
               tick     <= 1'b0;
               tick_cnt <= tick_cnt + 1'b1;
            end
            default: state <= RESET;
         endcase
      end
   end
endmodule
